// File: rtl/spi_master_cmd_if.sv
// Host command handshake plus SPI pin bundle for the 10-bit command SPI link.
// The master modport is the initiator side and the slave modport is the host/pin side.
interface spi_master_cmd_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_type;
    logic [7:0] cmd_data;
    logic       resp_valid;
    logic [7:0] resp_data;
    logic       rd_seq_err;
    logic       busy;
    logic       ss_n;
    logic       mosi;
    logic       miso;

    modport master (
        input  cmd_valid, cmd_type, cmd_data, miso,
        output cmd_ready, resp_valid, resp_data, rd_seq_err, busy, ss_n, mosi
    );

    modport slave (
        output cmd_valid, cmd_type, cmd_data, miso,
        input  cmd_ready, resp_valid, resp_data, rd_seq_err, busy, ss_n, mosi
    );
endinterface

// File: rtl/spi_master_cmd.sv
// Initiator for the 10-bit command SPI link: shifts {type, payload} out MSB first
// on the shared clock and collects an 8-bit reply for read-data commands.
module spi_master_cmd #(
    parameter int unsigned TURNAROUND = 1,
    parameter int unsigned GAP_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    spi_master_cmd_if.master bus
);

    typedef enum logic [2:0] {IDLE, SEL, SHIFT, TURN, RECV, GAP} state_t;

    localparam logic [3:0] GAP_LAST  = 4'(GAP_CYCLES - 1);
    localparam logic [3:0] TURN_LAST = 4'(TURNAROUND - 1);

    state_t     state_q;
    logic [9:0] frame_q;
    logic [1:0] type_q;
    logic [3:0] cnt_q;
    logic [7:0] rx_q;
    logic [7:0] resp_data_q;
    logic       resp_valid_q;
    logic       rd_seq_err_q;
    logic       rd_addr_pend_q;
    logic       ss_n_q;
    logic       mosi_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= IDLE;
            frame_q        <= '0;
            type_q         <= '0;
            cnt_q          <= '0;
            rx_q           <= '0;
            resp_data_q    <= '0;
            resp_valid_q   <= 1'b0;
            rd_seq_err_q   <= 1'b0;
            rd_addr_pend_q <= 1'b0;
            ss_n_q         <= 1'b1;
            mosi_q         <= 1'b0;
        end else begin
            resp_valid_q <= 1'b0;
            rd_seq_err_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        frame_q      <= {bus.cmd_type, bus.cmd_data};
                        type_q       <= bus.cmd_type;
                        cnt_q        <= '0;
                        ss_n_q       <= 1'b0;
                        mosi_q       <= bus.cmd_type[1];
                        rd_seq_err_q <= (bus.cmd_type == 2'b11) && !rd_addr_pend_q;
                        state_q      <= SEL;
                    end
                end
                // SEL is the slave's check slot, so the MSB is presented twice.
                SEL: begin
                    mosi_q  <= frame_q[9];
                    state_q <= SHIFT;
                end
                SHIFT: begin
                    if (cnt_q == 4'd9) begin
                        cnt_q  <= '0;
                        mosi_q <= 1'b0;
                        if (type_q == 2'b11) begin
                            state_q <= (TURNAROUND == 0) ? RECV : TURN;
                        end else begin
                            ss_n_q  <= 1'b1;
                            state_q <= GAP;
                            if (type_q == 2'b10) begin
                                rd_addr_pend_q <= 1'b1;
                            end
                        end
                    end else begin
                        cnt_q   <= cnt_q + 4'd1;
                        mosi_q  <= frame_q[8];
                        frame_q <= {frame_q[8:0], 1'b0};
                    end
                end
                TURN: begin
                    if (cnt_q == TURN_LAST) begin
                        cnt_q   <= '0;
                        state_q <= RECV;
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                RECV: begin
                    rx_q <= {rx_q[6:0], bus.miso};
                    if (cnt_q == 4'd7) begin
                        resp_data_q    <= {rx_q[6:0], bus.miso};
                        resp_valid_q   <= 1'b1;
                        rd_addr_pend_q <= 1'b0;
                        ss_n_q         <= 1'b1;
                        cnt_q          <= '0;
                        state_q        <= GAP;
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                GAP: begin
                    if (cnt_q == GAP_LAST) begin
                        cnt_q   <= '0;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.cmd_ready  = (state_q == IDLE);
    assign bus.busy       = (state_q != IDLE);
    assign bus.ss_n       = ss_n_q;
    assign bus.mosi       = mosi_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_data  = resp_data_q;
    assign bus.rd_seq_err = rd_seq_err_q;

endmodule
